// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor short-circuits through BYZERO to a 0/0 result.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, BYZERO = 2'd2, END = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd3} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvsr;
  logic          neg_quo;
  logic          neg_rem;

  logic [W-1:0]  dvd_abs;
  logic [W-1:0]  dvs_abs;
  logic [W:0]    shifted;
  logic          borrow;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  quo_nxt;
  logic [W-1:0]  rem_fix;
  logic [W-1:0]  quo_fix;

  // Magnitudes of the operands; DIVU passes them through untouched.
  always_comb begin
    dvd_abs = (signed_div_i && opdata1_i[W-1]) ? W'(-opdata1_i) : opdata1_i;
    dvs_abs = (signed_div_i && opdata2_i[W-1]) ? W'(-opdata2_i) : opdata2_i;
  end

  // One restoring step; the shifted partial remainder needs 33 bits before the trial subtract.
  always_comb begin
    shifted = {rem, quo[W-1]};
    borrow  = shifted < {1'b0, dvsr};
    rem_nxt = borrow ? shifted[W-1:0] : W'(shifted - {1'b0, dvsr});
    quo_nxt = {quo[W-2:0], ~borrow};
    quo_fix = neg_quo ? W'(-quo_nxt) : quo_nxt;
    rem_fix = neg_rem ? W'(-rem_nxt) : rem_nxt;
  end

`ifdef DIV_ZERO_FAST_EN
  assign busy_o = (state == ON) || (state == BYZERO);
`else
  assign busy_o = (state == ON);
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i && (state != IDLE)) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            rem     <= '0;
            quo     <= dvd_abs;
            dvsr    <= dvs_abs;
            neg_quo <= signed_div_i & (opdata1_i[W-1] ^ opdata2_i[W-1]);
            neg_rem <= signed_div_i & opdata1_i[W-1];
            cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
            state   <= (opdata2_i == '0) ? BYZERO : ON;
`else
            state   <= ON;
`endif
          end
        end
        ON: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
`ifdef DIV_ZERO_FAST_EN
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= END;
        end
`endif
        END: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ready_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results, zero divisor, annul, reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks;
  int errors;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request; it is accepted on the next rising edge (end of C0).
  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Wait for ready_o with start_i held, scrambling operands after accept; checks busy, latency, result.
  task automatic wait_ready(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int n;
    @(posedge clk);
    #1;
    opdata1_i    = 32'hDEAD_BEEF;
    opdata2_i    = 32'h0000_0003;
    signed_div_i = ~signed_div_i;
    n = 1;
    @(negedge clk);
    check({tag, "_busy_c1"}, 64'(busy_o), 64'd1);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
  endtask

  // Keep start_i high for extra cycles in END, then drop it and confirm the return to IDLE.
  task automatic finish_op(input string tag, input int hold, input logic [63:0] exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, exp_res);
  endtask

  initial begin
    int seen;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;

    #3;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with start held five extra cycles in END
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready("divu_100_7", 33, {32'h0000_0002, 32'h0000_000E});
    finish_op("divu_100_7", 5, {32'h0000_0002, 32'h0000_000E});

    // Back-to-back: accepted on the IDLE cycle right after the drop
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready("div_m7_2", 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    finish_op("div_m7_2", 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready("div_min_m1", 33, {32'h0000_0000, 32'h8000_0000});
    finish_op("div_min_m1", 0, {32'h0000_0000, 32'h8000_0000});

    start_op(1'b1, 32'd20, 32'hFFFF_FFFA);
    wait_ready("div_20_m6", 33, {32'h0000_0002, 32'hFFFF_FFFD});
    finish_op("div_20_m6", 1, {32'h0000_0002, 32'hFFFF_FFFD});

    start_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_ready("divu_max_1", 33, {32'h0000_0000, 32'hFFFF_FFFF});
    finish_op("divu_max_1", 0, {32'h0000_0000, 32'hFFFF_FFFF});

`ifdef DIV_ZERO_FAST_EN
    start_op(1'b0, 32'd5, 32'd0);
    wait_ready("divu_5_0", 2, 64'd0);
    finish_op("divu_5_0", 1, 64'd0);
    start_op(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_ready("div_m5_0", 2, 64'd0);
    finish_op("div_m5_0", 0, 64'd0);
`else
    start_op(1'b0, 32'd5, 32'd0);
    wait_ready("divu_5_0", 33, {32'h0000_0005, 32'hFFFF_FFFF});
    finish_op("divu_5_0", 1, {32'h0000_0005, 32'hFFFF_FFFF});
    start_op(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_ready("div_m5_0", 33, {32'hFFFF_FFFB, 32'h0000_0001});
    finish_op("div_m5_0", 0, {32'hFFFF_FFFB, 32'h0000_0001});
`endif

    // Annul pulsed in C10 together with the start drop
    start_op(1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_busy_c11", 64'(busy_o), 64'd0);
    check("annul_ready_c11", 64'(ready_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check("annul_ready_never", 64'(seen), 64'd0);
    check("annul_result_kept", result_o, {32'hFFFF_FFFB, 32'h0000_0001}
`ifdef DIV_ZERO_FAST_EN
      & 64'd0
`endif
    );

    start_op(1'b0, 32'd9, 32'd3);
    wait_ready("divu_9_3", 33, {32'h0000_0000, 32'h0000_0003});
    finish_op("divu_9_3", 0, {32'h0000_0000, 32'h0000_0003});

    // Start together with annul in IDLE is ignored
    start_op(1'b0, 32'd50, 32'd5);
    annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    check("annul_idle_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("annul_idle_ready", 64'(ready_o), 64'd0);

    // Asynchronous reset between edges in the middle of ON
    start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_result", result_o, 64'd0);
    check("arst_ready", 64'(ready_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_ready("post_rst", 33, {32'h0000_000F, 32'h0FFF_FFFF});
    finish_op("post_rst", 0, {32'h0000_000F, 32'h0FFF_FFFF});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
